// File: rtl/regfile_2r1w_clr_pkg.sv
// ============================================================================
//  Module      : regfile_2r1w_clr_pkg
//  Description : Shared widths and clear-FSM state encodings for the
//                2-read/1-write register file.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

package regfile_2r1w_clr_pkg;

    localparam int RF_DEFAULT_WIDTH = `DEFAULT_WIDTH;

    typedef logic [0:0] rf_state_t;

    localparam logic [0:0] RF_ST_CLEAR = 1'b0;
    localparam logic [0:0] RF_ST_READY = 1'b1;

endpackage

`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
// ============================================================================
//  Module      : regfile_clear_fsm
//  Description : Sweep sequencer that zeroes every register file entry after
//                reset or on request, then flags the file ready.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_fsm
    import regfile_2r1w_clr_pkg::*;
#(
    parameter int bits = 3
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clear_req,
    output logic            ready,
    output logic            clr_we,
    output logic [bits-1:0] clr_addr
);

    localparam logic [bits-1:0] c_last_idx = '1;

    rf_state_t       r_state;
    logic [bits-1:0] r_clr_idx;
    logic            r_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= RF_ST_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                RF_ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == c_last_idx) begin
                        r_state <= RF_ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                RF_ST_READY: begin
                    if (clear_req) begin
                        r_state   <= RF_ST_CLEAR;
                        r_clr_idx <= '0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RF_ST_CLEAR;
                    r_clr_idx <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Reset itself must never disturb memory contents.
    assign clr_we   = reset_n & (r_state == RF_ST_CLEAR);
    assign clr_addr = r_clr_idx;
    assign ready    = r_ready;

endmodule

`default_nettype wire

// File: rtl/regfile_2r1w_clr.sv
// ============================================================================
//  Module      : regfile_2r1w_clr
//  Description : 2-read/1-write register file with sequential clear sweep and
//                optional hardwired-zero entry 0.
//                Define REGFILE_BYPASS_EN for write-first read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w_clr
    import regfile_2r1w_clr_pkg::*;
#(
    parameter int n        = RF_DEFAULT_WIDTH,
    parameter int bits     = 3,
    parameter int ZERO_REG = 0
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            clear_req,
    input  logic            write_enable,
    input  logic [bits-1:0] write_addr,
    input  logic [n-1:0]    write_data,
    input  logic [bits-1:0] read_addr_a,
    input  logic [bits-1:0] read_addr_b,
    output logic [n-1:0]    read_data_a,
    output logic [n-1:0]    read_data_b,
    output logic            ready
);

    localparam int c_depth    = 2 ** bits;
    localparam bit c_zero_reg = (ZERO_REG != 0);

    logic [n-1:0]    r_mem [c_depth];
    logic            w_ready;
    logic            w_clr_we;
    logic [bits-1:0] w_clr_addr;
    logic            w_ext_we;
    logic [bits-1:0] w_raddr [2];
    logic [n-1:0]    w_rdata [2];

    regfile_clear_fsm #(
        .bits      (bits)
    ) u_clear_fsm (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .ready     (w_ready),
        .clr_we    (w_clr_we),
        .clr_addr  (w_clr_addr)
    );

    // A clear request wins over a coincident write; entry 0 drops writes when hardwired.
    assign w_ext_we = reset_n & w_ready & write_enable & ~clear_req
                    & ~(c_zero_reg & (write_addr == '0));

    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_ext_we) begin
            r_mem[write_addr] <= write_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_bypass_ok;
    assign w_bypass_ok = w_ready & write_enable & ~clear_req;
`endif

    assign w_raddr[0] = read_addr_a;
    assign w_raddr[1] = read_addr_b;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        always_comb begin
            w_rdata[p] = r_mem[w_raddr[p]];
`ifdef REGFILE_BYPASS_EN
            if (w_bypass_ok && (write_addr == w_raddr[p])) begin
                w_rdata[p] = write_data;
            end
`endif
            if (!w_ready || (c_zero_reg && (w_raddr[p] == '0))) begin
                w_rdata[p] = '0;
            end
        end
    end

    assign read_data_a = w_rdata[0];
    assign read_data_b = w_rdata[1];
    assign ready       = w_ready;

endmodule

`default_nettype wire
